keccak_rate_buffer: RTL and testbench

KECCAK_RATE_BUFFER -- requirements
Module: keccak_rate_buffer

---
 rtl/keccak_rate_buffer.sv | 125 ++++++++++++
 tb/tb_keccak_rate_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_rate_buffer.sv
// Keccak rate buffer: packs W-bit message words into a RATE_WORDS*W block
// for the permutation and serialises the squeezed digest back out in W-bit words.
//
// Ports:
//   Clock, Reset            rising-edge clock, async active-high reset
//   Din/Din_valid/Din_ready message word input handshake
//   Last_block              final-block flag, taken with the last word of a block
//   Block_out/Block_valid/Block_ready  assembled block to the permutation
//   Digest_in/Digest_valid  squeezed state from the permutation
//   Dout/Dout_valid/Dout_ready         digest word output handshake
module keccak_rate_buffer #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 16,
  parameter int OUT_WORDS  = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [W-1:0]            Din,
  input  logic                    Din_valid,
  output logic                    Din_ready,
  input  logic                    Last_block,
  output logic [RATE_WORDS*W-1:0] Block_out,
  output logic                    Block_valid,
  input  logic                    Block_ready,
  input  logic [OUT_WORDS*W-1:0]  Digest_in,
  input  logic                    Digest_valid,
  output logic [W-1:0]            Dout,
  output logic                    Dout_valid,
  input  logic                    Dout_ready
);

  localparam int BW   = RATE_WORDS * W;
  localparam int DW   = OUT_WORDS * W;
  localparam int INW  = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int OUTW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  localparam logic [INW-1:0]  IN_LAST  = INW'(RATE_WORDS - 1);
  localparam logic [OUTW-1:0] OUT_LAST = OUTW'(OUT_WORDS - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      r_state;
  logic [BW-1:0]   r_data;
  logic [INW-1:0]  r_in_cnt;
  logic [OUTW-1:0] r_out_cnt;
  logic            r_last;

  logic [BW-1:0]   w_fill_data;
  logic [BW-1:0]   w_drain_data;
  logic            w_in_end;
  logic            w_out_end;

  // New word enters at the top; after a full block the first word
  // has walked down to the least significant lane.
  always_comb begin
    w_fill_data = r_data >> W;
    w_fill_data[BW-1 -: W] = Din;
  end

  assign w_drain_data = r_data >> W;
  assign w_in_end     = (r_in_cnt == IN_LAST);
  assign w_out_end    = (r_out_cnt == OUT_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_FILL;
      r_data    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_last    <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (Din_valid) begin
            r_data <= w_fill_data;
            if (w_in_end) begin
              r_in_cnt <= '0;
              r_last   <= Last_block;
              r_state  <= S_FULL;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (Block_ready) begin
            r_state <= r_last ? S_WAIT : S_FILL;
          end
        end
        S_WAIT: begin
          // Only the low digest lanes are replaced; upper lanes are
          // don't-care while draining.
          if (Digest_valid) begin
            r_data[DW-1:0] <= Digest_in;
            r_out_cnt      <= '0;
            r_state        <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (Dout_ready) begin
            r_data <= w_drain_data;
            if (w_out_end) begin
              r_out_cnt <= '0;
              r_last    <= 1'b0;
              r_state   <= S_FILL;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign Din_ready   = (r_state == S_FILL);
  assign Block_valid = (r_state == S_FULL);
  assign Dout_valid  = (r_state == S_DRAIN);
  assign Block_out   = r_data;
  assign Dout        = r_data[W-1:0];

endmodule

// File: tb/tb_keccak_rate_buffer.sv
// Bench for keccak_rate_buffer: transaction-level model for the default
// instance, plus directed literal checks on default and 32/18/8 instances.
module tb_keccak_rate_buffer;

  localparam int W  = 64;
  localparam int RW = 16;
  localparam int OW = 4;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [W-1:0]    Din = '0;
  logic            Din_valid = 1'b0;
  logic            Din_ready;
  logic            Last_block = 1'b0;
  logic [RW*W-1:0] Block_out;
  logic            Block_valid;
  logic            Block_ready = 1'b0;
  logic [OW*W-1:0] Digest_in = '0;
  logic            Digest_valid = 1'b0;
  logic [W-1:0]    Dout;
  logic            Dout_valid;
  logic            Dout_ready = 1'b0;

  logic [31:0]     t2_din = '0;
  logic            t2_din_valid = 1'b0;
  logic            t2_din_ready;
  logic            t2_last = 1'b0;
  logic [575:0]    t2_block;
  logic            t2_block_valid;
  logic            t2_block_ready = 1'b0;
  logic [255:0]    t2_digest = '0;
  logic            t2_digest_valid = 1'b0;
  logic [31:0]     t2_dout;
  logic            t2_dout_valid;
  logic            t2_dout_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  keccak_rate_buffer #(.W(W), .RATE_WORDS(RW), .OUT_WORDS(OW)) dut (
    .Clock(Clock), .Reset(Reset),
    .Din(Din), .Din_valid(Din_valid), .Din_ready(Din_ready),
    .Last_block(Last_block),
    .Block_out(Block_out), .Block_valid(Block_valid),
    .Block_ready(Block_ready),
    .Digest_in(Digest_in), .Digest_valid(Digest_valid),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready)
  );

  keccak_rate_buffer #(.W(32), .RATE_WORDS(18), .OUT_WORDS(8)) dut2 (
    .Clock(Clock), .Reset(Reset),
    .Din(t2_din), .Din_valid(t2_din_valid), .Din_ready(t2_din_ready),
    .Last_block(t2_last),
    .Block_out(t2_block), .Block_valid(t2_block_valid),
    .Block_ready(t2_block_ready),
    .Digest_in(t2_digest), .Digest_valid(t2_digest_valid),
    .Dout(t2_dout), .Dout_valid(t2_dout_valid), .Dout_ready(t2_dout_ready)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: words of the block being collected, whether a
  // complete block awaits the permutation, whether a digest is owed,
  // and the queue of digest words still to be emitted.
  logic [63:0] m_words[$];
  logic [63:0] m_dq[$];
  logic        m_pend;
  logic        m_last;
  logic        m_owed;

  function automatic logic m_can_fill();
    return !m_pend && !m_owed && (m_dq.size() == 0);
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_words.delete();
      m_dq.delete();
      m_pend <= 1'b0;
      m_last <= 1'b0;
      m_owed <= 1'b0;
    end else if (m_can_fill()) begin
      if (Din_valid) begin
        if (m_words.size() == RW - 1) begin
          m_pend <= 1'b1;
          m_last <= Last_block;
        end
        m_words.push_back(Din);
      end
    end else if (m_pend) begin
      if (Block_ready) begin
        m_pend <= 1'b0;
        m_owed <= m_last;
        m_words.delete();
      end
    end else if (m_owed) begin
      if (Digest_valid) begin
        m_owed <= 1'b0;
        for (int i = 0; i < OW; i++) m_dq.push_back(Digest_in[i*W +: W]);
      end
    end else if (Dout_ready) begin
      void'(m_dq.pop_front());
    end
  end

  always @(negedge Clock) begin
    chk("m_din_ready", 64'(Din_ready), 64'(m_can_fill()));
    chk("m_block_valid", 64'(Block_valid), 64'(m_pend));
    chk("m_dout_valid", 64'(Dout_valid), 64'(m_dq.size() > 0));
    if (m_dq.size() > 0) chk("m_dout", Dout, m_dq[0]);
    if (m_pend) begin
      int bad;
      bad = -1;
      for (int k = RW - 1; k >= 0; k--)
        if (Block_out[k*W +: W] !== m_words[k]) bad = k;
      if (bad < 0) chk("m_block", 64'd0, 64'd0 + 64'(bad + 1));
      else chk($sformatf("m_block_w%0d", bad), Block_out[bad*W +: W],
               m_words[bad]);
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input logic lb);
    int n;
    n = 0;
    while (!Din_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_timeout: got din_ready=0 expected 1");
    end
    Din = w;
    Last_block = lb;
    Din_valid = 1'b1;
    step();
    Din_valid = 1'b0;
    Last_block = 1'b0;
  endtask

  task automatic pulse_block_ready();
    Block_ready = 1'b1;
    step();
    Block_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_din_ready"}, 64'(Din_ready), 64'd1);
    chk({tag, "_block_valid"}, 64'(Block_valid), 64'd0);
    chk({tag, "_dout_valid"}, 64'(Dout_valid), 64'd0);
    chk({tag, "_block_zero"}, 64'(Block_out != '0), 64'd0);
    chk({tag, "_dout"}, Dout, 64'd0);
  endtask

  logic [RW*W-1:0] saved;

  initial begin
    step();
    step();
    chk_reset_outs("rst0");
    Reset = 1'b0;
    step();

    // Plain block k=0..15
    for (int k = 0; k < RW; k++) send(64'(k), 1'b0);
    chk("blk1_valid", 64'(Block_valid), 64'd1);
    chk("blk1_din_ready", 64'(Din_ready), 64'd0);
    for (int k = 0; k < RW; k += 5)
      chk($sformatf("blk1_w%0d", k), Block_out[k*W +: W], 64'(k));
    chk("blk1_w15", Block_out[15*W +: W], 64'd15);

    // Stall in FULL with stray Din_valid, Digest_valid, Dout_ready
    saved = Block_out;
    Din = 64'hAAAA;
    Din_valid = 1'b1;
    Dout_ready = 1'b1;
    Digest_in = {4{64'hBAD0BAD0}};
    for (int i = 0; i < 5; i++) begin
      Digest_valid = (i == 2);
      step();
    end
    Din_valid = 1'b0;
    Dout_ready = 1'b0;
    Digest_valid = 1'b0;
    chk("stall_valid", 64'(Block_valid), 64'd1);
    chk("stall_stable", 64'(Block_out == saved), 64'd1);
    chk("stall_w3", Block_out[3*W +: W], 64'd3);
    pulse_block_ready();
    chk("rel_din_ready", 64'(Din_ready), 64'd1);
    chk("rel_block_valid", 64'(Block_valid), 64'd0);
    chk("rel_dout_valid", 64'(Dout_valid), 64'd0);

    // Final block and digest drain with backpressure after B
    for (int k = 0; k < RW; k++) send(64'(100 + k), k == RW - 1);
    chk("blk2_w0", Block_out[W-1:0], 64'd100);
    pulse_block_ready();
    chk("wait_din_ready", 64'(Din_ready), 64'd0);
    chk("wait_dout_valid", 64'(Dout_valid), 64'd0);
    Digest_in = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
    Digest_valid = 1'b1;
    step();
    Digest_valid = 1'b0;
    chk("drain_valid", 64'(Dout_valid), 64'd1);
    chk("drain_a", Dout, 64'hAAAA);
    Dout_ready = 1'b1;
    step();
    Dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_b", Dout, 64'hBBBB);
      chk("hold_valid", 64'(Dout_valid), 64'd1);
    end
    Dout_ready = 1'b1;
    step();
    chk("drain_c", Dout, 64'hCCCC);
    step();
    chk("drain_d", Dout, 64'hDDDD);
    step();
    Dout_ready = 1'b0;
    chk("done_dout_valid", 64'(Dout_valid), 64'd0);
    chk("done_din_ready", 64'(Din_ready), 64'd1);

    // Reset after 7 accepts
    for (int k = 0; k < 7; k++) send(64'(50 + k), 1'b0);
    Reset = 1'b1;
    #1;
    chk_reset_outs("rst7");
    step();
    Reset = 1'b0;
    for (int k = 0; k < RW; k++) send(64'(200 + k), k == RW - 1);
    chk("clean1_w0", Block_out[W-1:0], 64'd200);
    chk("clean1_w15", Block_out[15*W +: W], 64'd215);
    pulse_block_ready();
    Digest_in = {64'h4, 64'h3, 64'h2, 64'h1};
    Digest_valid = 1'b1;
    step();
    Digest_valid = 1'b0;
    Dout_ready = 1'b1;
    step();
    Dout_ready = 1'b0;
    chk("mid_drain", Dout, 64'h2);

    // Reset mid-DRAIN
    Reset = 1'b1;
    #1;
    chk_reset_outs("rstd");
    step();
    Reset = 1'b0;
    for (int k = 0; k < RW; k++) send(64'(300 + k), 1'b0);
    chk("clean2_w0", Block_out[W-1:0], 64'd300);
    chk("clean2_w9", Block_out[9*W +: W], 64'd309);
    pulse_block_ready();
    chk("clean2_fill", 64'(Din_ready), 64'd1);

    // W=32, RATE_WORDS=18, OUT_WORDS=8 instance
    for (int k = 0; k < 18; k++) begin
      int n;
      n = 0;
      while (!t2_din_ready && n < 50) begin
        step();
        n++;
      end
      chk("t2_fill_ready", 64'(t2_din_ready), 64'd1);
      t2_din = 32'h1000 + 32'(k);
      t2_last = (k == 17);
      t2_din_valid = 1'b1;
      step();
      t2_din_valid = 1'b0;
      t2_last = 1'b0;
      if (k < 17) chk("t2_not_full", 64'(t2_block_valid), 64'd0);
    end
    chk("t2_block_valid", 64'(t2_block_valid), 64'd1);
    chk("t2_din_ready", 64'(t2_din_ready), 64'd0);
    chk("t2_w0", 64'(t2_block[31:0]), 64'h1000);
    chk("t2_w17", 64'(t2_block[17*32 +: 32]), 64'h1011);
    t2_block_ready = 1'b1;
    step();
    t2_block_ready = 1'b0;
    for (int i = 0; i < 8; i++) t2_digest[i*32 +: 32] = 32'hD0 + 32'(i);
    t2_digest_valid = 1'b1;
    step();
    t2_digest_valid = 1'b0;
    t2_dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_dout_valid%0d", i), 64'(t2_dout_valid), 64'd1);
      chk($sformatf("t2_dout%0d", i), 64'(t2_dout), 64'hD0 + 64'(i));
      step();
    end
    t2_dout_ready = 1'b0;
    chk("t2_end_valid", 64'(t2_dout_valid), 64'd0);
    chk("t2_end_ready", 64'(t2_din_ready), 64'd1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
